// File: rtl/fault_stim_gen.sv
// Stimulus generator for a fault detector: a baseline window, an idle gap and a test
// window of per-channel samples, with an optional offset on one channel and LFSR noise.
module fault_stim_gen #(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] base,
  input  logic [1:0] fault_ch,
  input  logic [7:0] fault_mag,
  input  logic       noise_en,
  output logic [7:0] r0,
  output logic [1:0] check,
  output logic       valid,
  output logic       window,
  output logic       busy,
  output logic       done
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SUM_W  = 10;
  localparam int unsigned CH_W   = 2;

  localparam logic [IDX_W-1:0]  IDX_LAST  = '1;
  localparam logic [IDX_W-1:0]  GAP_LAST  = IDX_W'(GAP_CYCLES - 1);
  localparam logic [DATA_W-1:0] LFSR_SEED = 8'hA5;
  // Feedback taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3).
  localparam logic [DATA_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BASE,
    S_GAP,
    S_TEST,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  base_q, base_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [DATA_W-1:0]  mag_q, mag_d;
  logic               noise_q, noise_d;
  logic [DATA_W-1:0]  lfsr_q, lfsr_d;

  logic [DATA_W-1:0]  r0_d;
  logic [CH_W-1:0]    check_d;
  logic               valid_d;
  logic               window_d;
  logic               busy_d;
  logic               done_d;
  logic [CH_W-1:0]    noise_val;
  logic [SUM_W-1:0]   sum;

  // Outputs are registered from the next-state view so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      ch_q    <= '0;
      mag_q   <= '0;
      noise_q <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      r0      <= '0;
      check   <= '0;
      valid   <= 1'b0;
      window  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      ch_q    <= ch_d;
      mag_q   <= mag_d;
      noise_q <= noise_d;
      lfsr_q  <= lfsr_d;
      r0      <= r0_d;
      check   <= check_d;
      valid   <= valid_d;
      window  <= window_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    base_d    = base_q;
    ch_d      = ch_q;
    mag_d     = mag_q;
    noise_d   = noise_q;
    lfsr_d    = lfsr_q;
    r0_d      = '0;
    check_d   = '0;
    valid_d   = 1'b0;
    window_d  = window;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    noise_val = '0;
    sum       = '0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_BASE;
          idx_d   = '0;
          base_d  = base;
          ch_d    = fault_ch;
          mag_d   = fault_mag;
          noise_d = noise_en;
        end
      end
      S_BASE: begin
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = (GAP_CYCLES == 0) ? S_TEST : S_GAP;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_GAP: begin
        if (idx_q == GAP_LAST) begin
          idx_d   = '0;
          state_d = S_TEST;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_TEST: begin
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end

    valid_d = (state_d == S_BASE) || (state_d == S_TEST);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);

    // Sample path: 10-bit sum saturated to 8 bits; LFSR steps once per emitted sample.
    if (valid_d) begin
      noise_val = noise_d ? lfsr_q[CH_W-1:0] : '0;
      sum       = SUM_W'(base_d) + SUM_W'(noise_val);
      if ((state_d == S_TEST) && (idx_d[CH_W-1:0] == ch_d)) begin
        sum = sum + SUM_W'(mag_d);
      end
      r0_d     = (|sum[SUM_W-1:DATA_W]) ? '1 : sum[DATA_W-1:0];
      check_d  = idx_d[CH_W-1:0];
      window_d = (state_d == S_TEST);
      lfsr_d   = {lfsr_q[DATA_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    end else if (state_d == S_IDLE) begin
      window_d = 1'b0;
    end
  end

endmodule
